cu_fsm: RTL and testbench

Multicycle sequencer for the RV32I core. It steps each instruction through fetch, execute and (for loads) writeback, and stalls on memory ready handshakes. It owns the interrupt-pending logic and drives the write enables for the PC, register file, data memory and CSR file. It sits beside the combinational control decoder; int_taken from this block steers the decoder's PC-source mux to mtvec.

---
 rtl/otter_pkg.sv | 30 +++
 rtl/cu_fsm_intr_sync.sv | 41 ++++
 rtl/cu_fsm.sv | 147 ++++++++++++++
 tb/tb_cu_fsm.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/otter_pkg.sv
// Shared RV32I control types: opcodes, SYS func3 codes and the control-unit states.
package otter_pkg;

  typedef enum logic [6:0] {
    LUI    = 7'b0110111,
    AUIPC  = 7'b0010111,
    JAL    = 7'b1101111,
    JALR   = 7'b1100111,
    BRANCH = 7'b1100011,
    LOAD   = 7'b0000011,
    STORE  = 7'b0100011,
    OP_IMM = 7'b0010011,
    OP_RG3 = 7'b0110011,
    SYS    = 7'b1110011
  } opcode_t;

  localparam logic [2:0] MRET  = 3'b000;
  localparam logic [2:0] CSRRW = 3'b001;
  localparam logic [2:0] CSRRS = 3'b010;
  localparam logic [2:0] CSRRC = 3'b011;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WB    = 3'd3,
    ST_INTR  = 3'd4
  } cu_state_t;

endpackage

// File: rtl/cu_fsm_intr_sync.sv
// External interrupt synchroniser and sticky pending flag.
module intr_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic intr,
  input  logic mie,
  input  logic clr,
  output logic int_pend
);

  logic [STAGES-1:0] sync_q;
  logic              intr_sync;

  assign intr_sync = sync_q[STAGES-1];

  // Shift the asynchronous request through the synchroniser chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= intr;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  // Pending flag: set while enabled, survives a later mie drop, clear wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      int_pend <= 1'b0;
    end else if (clr) begin
      int_pend <= 1'b0;
    end else if (intr_sync && mie) begin
      int_pend <= 1'b1;
    end
  end

endmodule

// File: rtl/cu_fsm.sv
// Multicycle RV32I sequencer: fetch, execute, load writeback, interrupt entry.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_INIT  | after reset; clears PC, always one cycle
// ST_FETCH | instruction read, waits for imem_ready
// ST_EXEC  | execute; stores wait here for dmem_ready
// ST_WB    | load writeback, waits for dmem_ready
// ST_INTR  | trap entry to mtvec, always one cycle
module cu_fsm
  import otter_pkg::*;
#(
  parameter int INTR_SYNC_STAGES = 2,
  parameter bit USE_MEM_READY    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       intr,
  input  logic       mie,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       pc_write,
  output logic       pc_rst,
  output logic       reg_write,
  output logic       mem_rden1,
  output logic       mem_rden2,
  output logic       mem_we2,
  output logic       csr_we,
  output logic       int_taken,
  output logic       mret_exec,
  output logic       illegal,
  output logic [2:0] state_o
);

  cu_state_t state_q, state_d;
  logic      int_pend;
  logic      imem_rdy, dmem_rdy;
  logic      done;

  assign imem_rdy = USE_MEM_READY ? imem_ready : 1'b1;
  assign dmem_rdy = USE_MEM_READY ? dmem_ready : 1'b1;
  assign state_o  = state_q;

  intr_sync #(.STAGES(INTR_SYNC_STAGES)) u_intr_sync (
    .clk      (clk),
    .rst      (rst),
    .intr     (intr),
    .mie      (mie),
    .clr      (state_q == ST_INTR),
    .int_pend (int_pend)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_INIT;
    else     state_q <= state_d;
  end

  // Next-state and control outputs; "done" marks an instruction boundary.
  always_comb begin
    state_d   = ST_INIT;
    done      = 1'b0;
    pc_write  = 1'b0;
    pc_rst    = 1'b0;
    reg_write = 1'b0;
    mem_rden1 = 1'b0;
    mem_rden2 = 1'b0;
    mem_we2   = 1'b0;
    csr_we    = 1'b0;
    int_taken = 1'b0;
    mret_exec = 1'b0;
    illegal   = 1'b0;
    case (state_q)
      ST_INIT: begin
        pc_rst  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        mem_rden1 = 1'b1;
        state_d   = imem_rdy ? ST_EXEC : ST_FETCH;
      end
      ST_EXEC: begin
        case (opcode)
          LOAD: begin
            mem_rden2 = 1'b1;
            state_d   = ST_WB;
          end
          STORE: begin
            mem_we2 = 1'b1;
            if (dmem_rdy) begin
              pc_write = 1'b1;
              done     = 1'b1;
            end else begin
              state_d = ST_EXEC;
            end
          end
          BRANCH: begin
            pc_write = 1'b1;
            done     = 1'b1;
          end
          LUI, AUIPC, JAL, JALR, OP_IMM, OP_RG3: begin
            pc_write  = 1'b1;
            reg_write = 1'b1;
            done      = 1'b1;
          end
          SYS: begin
            pc_write = 1'b1;
            done     = 1'b1;
            case (func3)
              CSRRW, CSRRS, CSRRC: begin
                reg_write = 1'b1;
                csr_we    = 1'b1;
              end
              MRET:    mret_exec = 1'b1;
              default: ;
            endcase
          end
          default: begin
            pc_write = 1'b1;
            illegal  = 1'b1;
            done     = 1'b1;
          end
        endcase
      end
      ST_WB: begin
        mem_rden2 = 1'b1;
        if (dmem_rdy) begin
          reg_write = 1'b1;
          pc_write  = 1'b1;
          done      = 1'b1;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_INTR: begin
        int_taken = 1'b1;
        pc_write  = 1'b1;
        state_d   = ST_FETCH;
      end
      default: state_d = ST_INIT;
    endcase
    if (done) state_d = int_pend ? ST_INTR : ST_FETCH;
  end

endmodule

// File: tb/tb_cu_fsm.sv
// Randomised and directed checks of cu_fsm against an instruction-level model.
module tb_cu_fsm;

  localparam int STAGES = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       intr = 1'b0, mie = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] func3 = '0;
  logic       imem_ready = 1'b1, dmem_ready = 1'b1;
  logic       pc_write, pc_rst, reg_write, mem_rden1, mem_rden2, mem_we2;
  logic       csr_we, int_taken, mret_exec, illegal;
  logic [2:0] state_o;

  always #5 clk = ~clk;

  cu_fsm #(.INTR_SYNC_STAGES(STAGES), .USE_MEM_READY(1'b1)) dut (
    .clk(clk), .rst(rst), .intr(intr), .mie(mie), .opcode(opcode), .func3(func3),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .pc_rst(pc_rst), .reg_write(reg_write),
    .mem_rden1(mem_rden1), .mem_rden2(mem_rden2), .mem_we2(mem_we2),
    .csr_we(csr_we), .int_taken(int_taken), .mret_exec(mret_exec),
    .illegal(illegal), .state_o(state_o)
  );

  // Observed bundle: pcw pcr rw rd1 rd2 we2 csr int mret ill state[2:0]
  logic [12:0] obs;
  assign obs = {pc_write, pc_rst, reg_write, mem_rden1, mem_rden2, mem_we2,
                csr_we, int_taken, mret_exec, illegal, state_o};

  int n_tests = 0;
  int n_fail  = 0;

  bit         model_pend;
  bit         intr_hist[$];
  bit         pend_at_last;
  bit         rand_irq = 1'b0;
  int         intr_pct = 0;
  logic       cur_intr = 1'b0, cur_mie = 1'b0;
  logic [6:0] cur_op = '0;
  logic [2:0] cur_f3 = '0;

  function automatic logic [12:0] vec(input bit pcw, pcr, rw, r1, r2, we, csr, it, mr, ill,
                                      input logic [2:0] st);
    return {pcw, pcr, rw, r1, r2, we, csr, it, mr, ill, st};
  endfunction

  function automatic logic [12:0] v_init();  return vec(0,1,0,0,0,0,0,0,0,0,3'd0); endfunction
  function automatic logic [12:0] v_fetch(); return vec(0,0,0,1,0,0,0,0,0,0,3'd1); endfunction
  function automatic logic [12:0] v_intr();  return vec(1,0,0,0,0,0,0,1,0,0,3'd4); endfunction

  // Single-cycle EXEC outputs for every opcode except LOAD/STORE.
  function automatic logic [12:0] exec_vec(input logic [6:0] op, input logic [2:0] f3);
    case (op)
      7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0010011, 7'b0110011:
        return vec(1,0,1,0,0,0,0,0,0,0,3'd2);
      7'b1100011:
        return vec(1,0,0,0,0,0,0,0,0,0,3'd2);
      7'b1110011:
        if (f3 == 3'b001 || f3 == 3'b010 || f3 == 3'b011) return vec(1,0,1,0,0,0,1,0,0,0,3'd2);
        else if (f3 == 3'b000)                             return vec(1,0,0,0,0,0,0,0,1,0,3'd2);
        else                                               return vec(1,0,0,0,0,0,0,0,0,0,3'd2);
      default:
        return vec(1,0,0,0,0,0,0,0,0,1,3'd2);
    endcase
  endfunction

  task automatic check(input string tag, input logic [12:0] got, input logic [12:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (pcw pcr rw rd1 rd2 we2 csr int mret ill st)",
               tag, got, exp);
    end
  endtask

  task automatic model_clear();
    model_pend = 1'b0;
    intr_hist.delete();
    repeat (STAGES) intr_hist.push_back(1'b0);
  endtask

  // One clock cycle: drive inputs after the edge, check mid-cycle, then advance the model.
  task automatic step(input string tag, input logic [12:0] exp, input bit im, input bit dm);
    @(posedge clk); #1;
    if (rand_irq) begin
      cur_intr = ($urandom_range(0, 99) < intr_pct);
      cur_mie  = ($urandom_range(0, 99) < 70);
    end
    opcode = cur_op; func3 = cur_f3;
    intr = cur_intr; mie = cur_mie;
    imem_ready = im; dmem_ready = dm;
    @(negedge clk);
    check(tag, obs, exp);
    pend_at_last = model_pend;
    if (exp[2:0] == 3'd4)               model_pend = 1'b0;
    else if (intr_hist[0] && cur_mie)   model_pend = 1'b1;
    void'(intr_hist.pop_front());
    intr_hist.push_back(cur_intr);
  endtask

  // Whole instruction: fst fetch stalls, dst data-memory stalls, optional trap entry.
  task automatic run_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                           input int fst, input int dst);
    cur_op = op; cur_f3 = f3;
    for (int i = 0; i < fst; i++) step({name, "_fetch_wait"}, v_fetch(), 1'b0, 1'($urandom));
    step({name, "_fetch"}, v_fetch(), 1'b1, 1'($urandom));
    if (op == 7'b0000011) begin
      step({name, "_exec_load"}, vec(0,0,0,0,1,0,0,0,0,0,3'd2), 1'($urandom), 1'($urandom));
      for (int i = 0; i < dst; i++)
        step({name, "_wb_wait"}, vec(0,0,0,0,1,0,0,0,0,0,3'd3), 1'($urandom), 1'b0);
      step({name, "_wb_done"}, vec(1,0,1,0,1,0,0,0,0,0,3'd3), 1'($urandom), 1'b1);
    end else if (op == 7'b0100011) begin
      for (int i = 0; i < dst; i++)
        step({name, "_store_wait"}, vec(0,0,0,0,0,1,0,0,0,0,3'd2), 1'($urandom), 1'b0);
      step({name, "_store_done"}, vec(1,0,0,0,0,1,0,0,0,0,3'd2), 1'($urandom), 1'b1);
    end else begin
      step({name, "_exec"}, exec_vec(op, f3), 1'($urandom), 1'($urandom));
    end
    if (pend_at_last) step({name, "_intr"}, v_intr(), 1'($urandom), 1'($urandom));
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk); #1;
    rst = 1'b1; cur_intr = 1'b0; intr = 1'b0;
    @(negedge clk);
    check({tag, "_rst_assert"}, obs, v_init());
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check({tag, "_init_cycle"}, obs, v_init());
    model_clear();
  endtask

  logic [6:0] op_tab [10] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                              7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b1110011};

  initial begin
    model_clear();
    cur_mie = 1'b0;

    do_reset("t1");
    run_instr("t1_opimm", 7'b0010011, 3'b000, 0, 0);
    run_instr("t1_next", 7'b0110011, 3'b000, 0, 0);

    run_instr("t2_load", 7'b0000011, 3'b010, 1, 3);
    run_instr("t3_store", 7'b0100011, 3'b010, 0, 2);

    cur_intr = 1'b1; cur_mie = 1'b1;
    run_instr("t4_rg3_irq", 7'b0110011, 3'b000, 3, 0);
    cur_intr = 1'b0; cur_mie = 1'b0;
    run_instr("t4_drain", 7'b0010011, 3'b000, 2, 0);
    run_instr("t4_drain2", 7'b0010011, 3'b000, 0, 0);
    cur_intr = 1'b1; cur_mie = 1'b0;
    run_instr("t4_rg3_nomie", 7'b0110011, 3'b000, 3, 0);
    cur_intr = 1'b0;

    run_instr("t5_csrrw", 7'b1110011, 3'b001, 0, 0);
    run_instr("t5_mret", 7'b1110011, 3'b000, 0, 0);
    run_instr("t5_ill", 7'b1111111, 3'b000, 0, 0);
    run_instr("t5_sysnop", 7'b1110011, 3'b101, 0, 0);

    // Reset in the middle of a writeback stall with an interrupt already pending.
    cur_intr = 1'b1; cur_mie = 1'b1;
    cur_op = 7'b0000011; cur_f3 = 3'b010;
    step("t6_fetch_wait", v_fetch(), 1'b0, 1'b0);
    step("t6_fetch", v_fetch(), 1'b1, 1'b0);
    step("t6_exec", vec(0,0,0,0,1,0,0,0,0,0,3'd2), 1'b1, 1'b0);
    step("t6_wb_wait", vec(0,0,0,0,1,0,0,0,0,0,3'd3), 1'b1, 1'b0);
    step("t6_wb_wait2", vec(0,0,0,0,1,0,0,0,0,0,3'd3), 1'b1, 1'b0);
    do_reset("t6");
    cur_intr = 1'b0; cur_mie = 1'b1;
    run_instr("t6_after", 7'b0010011, 3'b000, 2, 0);
    run_instr("t6_after2", 7'b0010011, 3'b000, 0, 0);

    rand_irq = 1'b1; intr_pct = 8;
    for (int n = 0; n < 80; n++) begin
      int         k;
      logic [6:0] op;
      k  = $urandom_range(0, 10);
      op = (k == 10) ? 7'($urandom) : op_tab[k];
      run_instr($sformatf("rnd%0d", n), op, 3'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 3));
    end
    rand_irq = 1'b0; cur_intr = 1'b0;

    do_reset("t_end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
